// File: rtl/qmult_sched_pkg.sv
// Shared definitions for the qmult scheduler: FSM encodings and a constant clog2.
package qmult_sched_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/qmult.sv
// Combinational Q-format multiplier: sign-magnitude product, truncated to N bits, with overflow flag.
module qmult #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic [N-1:0] i_multiplicand,
  input  logic [N-1:0] i_multiplier,
  output logic [N-1:0] o_result,
  output logic         ovr
);

  function automatic logic [N-1:0] twos_neg(input logic [N-1:0] v);
    return ~v + {{(N-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [N-1:0] to_mag(input logic [N-1:0] v);
    return v[N-1] ? twos_neg(v) : v;
  endfunction

  logic [2*N-1:0]   prod_s;
  logic [2*N-Q-1:0] scaled_s;
  logic [N-1:0]     frac_s;
  logic             sign_s;

  assign prod_s   = {{N{1'b0}}, to_mag(i_multiplicand)} * {{N{1'b0}}, to_mag(i_multiplier)};
  assign scaled_s = (2*N-Q)'(prod_s >> Q);
  assign sign_s   = i_multiplicand[N-1] ^ i_multiplier[N-1];
  assign frac_s   = {1'b0, scaled_s[N-2:0]};
  assign o_result = sign_s ? twos_neg(frac_s) : frac_s;
  // The top bit of the product is always zero, so including it in the OR is harmless.
  assign ovr      = |scaled_s[2*N-Q-1:N-1];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or above ptr, with wrap.
module rr_arbiter import qmult_sched_pkg::*; #(
  parameter int NREQ = 4,
  localparam int IDW = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  int   pos_s;
  logic found_s;

  // Scan NREQ positions starting at ptr and latch the first requester seen.
  always_comb begin
    grant   = '0;
    idx     = '0;
    found_s = 1'b0;
    pos_s   = 0;
    for (int i = 0; i < NREQ; i++) begin
      pos_s = (int'(ptr) + i >= NREQ) ? int'(ptr) + i - NREQ : int'(ptr) + i;
      if (!found_s && req[pos_s]) begin
        grant[pos_s] = 1'b1;
        idx          = IDW'(pos_s);
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/qmult_sched.sv
// Round-robin scheduler sharing one qmult among NREQ requesters, with a registered
// response channel and per-requester sticky overflow flags.
module qmult_sched import qmult_sched_pkg::*; #(
  parameter int Q    = 15,
  parameter int N    = 32,
  parameter int NREQ = 4,
  localparam int IDW = clog2(NREQ)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NREQ-1:0]   i_req_valid,
  output logic [NREQ-1:0]   o_req_ready,
  input  logic [NREQ*N-1:0] i_req_multiplicand,
  input  logic [NREQ*N-1:0] i_req_multiplier,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [IDW-1:0]    o_rsp_id,
  output logic [N-1:0]      o_rsp_result,
  output logic              o_rsp_ovr,
  output logic [NREQ-1:0]   o_ovr_sticky,
  input  logic [NREQ-1:0]   i_ovr_clr,
  output logic              o_busy
);

  logic [1:0]      state_r;
  logic [IDW-1:0]  ptr_r;
  logic [IDW-1:0]  id_r;
  logic [N-1:0]    mcand_r;
  logic [N-1:0]    mplier_r;
  logic [N-1:0]    result_r;
  logic            ovr_r;
  logic            rsp_valid_r;
  logic            busy_r;
  logic [NREQ-1:0] sticky_r;

  logic [NREQ-1:0] grant_s;
  logic [IDW-1:0]  gidx_s;
  logic [IDW-1:0]  ptr_next_s;
  logic [N-1:0]    sel_mcand_s;
  logic [N-1:0]    sel_mplier_s;
  logic [N-1:0]    prod_s;
  logic            prod_ovr_s;
  logic [NREQ-1:0] sticky_set_s;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (i_req_valid),
    .ptr   (ptr_r),
    .grant (grant_s),
    .idx   (gidx_s)
  );

  qmult #(.Q(Q), .N(N)) u_qmult (
    .i_multiplicand (mcand_r),
    .i_multiplier   (mplier_r),
    .o_result       (prod_s),
    .ovr            (prod_ovr_s)
  );

  // Grant visibility, operand select, pointer advance and sticky set request.
  always_comb begin
    o_req_ready  = '0;
    sticky_set_s = '0;
    sel_mcand_s  = i_req_multiplicand[gidx_s*N +: N];
    sel_mplier_s = i_req_multiplier[gidx_s*N +: N];
    ptr_next_s   = (gidx_s == IDW'(NREQ - 1)) ? '0 : gidx_s + IDW'(1);
    if (state_r == ST_IDLE) begin
      o_req_ready = grant_s;
    end else begin
      o_req_ready = '0;
    end
    if (state_r == ST_CALC && prod_ovr_s) begin
      sticky_set_s[id_r] = 1'b1;
    end else begin
      sticky_set_s = '0;
    end
  end

  // Scheduler FSM with operand capture and response register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= ST_IDLE;
      ptr_r       <= '0;
      id_r        <= '0;
      mcand_r     <= '0;
      mplier_r    <= '0;
      result_r    <= '0;
      ovr_r       <= 1'b0;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|grant_s) begin
            mcand_r  <= sel_mcand_s;
            mplier_r <= sel_mplier_s;
            id_r     <= gidx_s;
            ptr_r    <= ptr_next_s;
            state_r  <= ST_CALC;
            busy_r   <= 1'b1;
          end
        end
        ST_CALC: begin
          result_r    <= prod_s;
          ovr_r       <= prod_ovr_s;
          rsp_valid_r <= 1'b1;
          state_r     <= ST_DONE;
          busy_r      <= 1'b1;
        end
        ST_DONE: begin
          if (i_rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overflow: a set in the same cycle as a clear takes priority.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sticky_r <= '0;
    end else begin
      sticky_r <= (sticky_r & ~i_ovr_clr) | sticky_set_s;
    end
  end

  assign o_rsp_valid  = rsp_valid_r;
  assign o_rsp_id     = id_r;
  assign o_rsp_result = result_r;
  assign o_rsp_ovr    = ovr_r;
  assign o_ovr_sticky = sticky_r;
  assign o_busy       = busy_r;

endmodule

// File: tb/tb_qmult_sched.sv
// Bench for qmult_sched: directed scenarios plus randomized traffic, all outputs checked
// every cycle against a transaction-level model of the scheduler.
module tb_qmult_sched;

  localparam int Q    = 15;
  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] mcand;
  logic [NREQ*N-1:0] mplier;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      rsp_result;
  logic              rsp_ovr;
  logic [NREQ-1:0]   ovr_sticky;
  logic [NREQ-1:0]   ovr_clr;
  logic              busy;

  always #5 clk = ~clk;

  qmult_sched #(.Q(Q), .N(N), .NREQ(NREQ)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_req_valid        (req_valid),
    .o_req_ready        (req_ready),
    .i_req_multiplicand (mcand),
    .i_req_multiplier   (mplier),
    .o_rsp_valid        (rsp_valid),
    .i_rsp_ready        (rsp_ready),
    .o_rsp_id           (rsp_id),
    .o_rsp_result       (rsp_result),
    .o_rsp_ovr          (rsp_ovr),
    .o_ovr_sticky       (ovr_sticky),
    .i_ovr_clr          (ovr_clr),
    .o_busy             (busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: phase 0 = waiting for a grant, 1 = multiplying, 2 = response offered.
  int              ph_m;
  int              ptr_m;
  int              id_m;
  logic [N-1:0]    res_m;
  logic            ovr_m;
  logic [NREQ-1:0] sticky_m;
  bit              zeros_m;
  logic [NREQ-1:0] grant_e;
  logic [NREQ-1:0] acc_mask;

  logic            s_valid;
  logic [N-1:0]    s_result;
  logic            s_ovr;
  logic [IDW-1:0]  s_id;
  logic [NREQ-1:0] s_ready;
  logic [NREQ-1:0] s_sticky;

  function automatic logic [N:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    longint unsigned ma, mb, p, mag;
    logic [N-1:0] r;
    logic ov;
    ma  = a[N-1] ? ((64'd1 << N) - a) : a;
    mb  = b[N-1] ? ((64'd1 << N) - b) : b;
    p   = ma * mb;
    mag = (p >> Q) & ((64'd1 << (N - 1)) - 64'd1);
    ov  = ((p >> (N - 1 + Q)) != 64'd0);
    r   = N'(mag);
    if (a[N-1] ^ b[N-1]) r = ~r + 32'd1;
    return {ov, r};
  endfunction

  function automatic logic [NREQ-1:0] rr_pick(input int ptr, input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) begin
      if (v[(ptr + i) % NREQ]) return NREQ'(1) << ((ptr + i) % NREQ);
    end
    return '0;
  endfunction

  function automatic logic [N-1:0] rand_op();
    logic [N-1:0] v;
    case ($urandom_range(5, 0))
      0: v = 32'h8000_0000;
      1: v = 32'h7FFF_FFFF;
      2: v = 32'h0000_0000;
      3: v = $urandom & 32'h0003_FFFF;
      4: v = ~($urandom & 32'h0003_FFFF) + 32'd1;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: check outputs mid-cycle, then advance the model on the rising edge.
  task automatic cycle();
    logic [NREQ-1:0] exp_ready;
    logic [NREQ-1:0] set_m;
    #1;
    grant_e   = rr_pick(ptr_m, req_valid);
    exp_ready = (ph_m == 0) ? grant_e : '0;
    s_ready   = req_ready;
    s_valid   = rsp_valid;
    s_result  = rsp_result;
    s_ovr     = rsp_ovr;
    s_id      = rsp_id;
    s_sticky  = ovr_sticky;
    cmp("req_ready", req_ready, exp_ready);
    cmp("rsp_valid", rsp_valid, ph_m == 2);
    cmp("busy", busy, ph_m != 0);
    cmp("ovr_sticky", ovr_sticky, sticky_m);
    if (ph_m == 2) begin
      cmp("rsp_id", rsp_id, id_m);
      cmp("rsp_result", rsp_result, res_m);
      cmp("rsp_ovr", rsp_ovr, ovr_m);
    end else if (ph_m == 0 && zeros_m) begin
      cmp("rsp_id_rst", rsp_id, 0);
      cmp("rsp_result_rst", rsp_result, 0);
      cmp("rsp_ovr_rst", rsp_ovr, 0);
    end
    @(posedge clk);
    acc_mask = '0;
    set_m    = '0;
    if (rst) begin
      ph_m = 0; ptr_m = 0; sticky_m = '0; zeros_m = 1'b1;
    end else begin
      case (ph_m)
        0: if (grant_e != '0) begin
          for (int k = 0; k < NREQ; k++) if (grant_e[k]) id_m = k;
          {ovr_m, res_m} = ref_mul(mcand[id_m*N +: N], mplier[id_m*N +: N]);
          ptr_m    = (id_m + 1) % NREQ;
          ph_m     = 1;
          zeros_m  = 1'b0;
          acc_mask = grant_e;
        end
        1: begin
          ph_m = 2;
          if (ovr_m) set_m[id_m] = 1'b1;
        end
        2: if (rsp_ready) ph_m = 0;
        default: ph_m = 0;
      endcase
      sticky_m = (sticky_m & ~ovr_clr) | set_m;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic send(input int k, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic [NREQ-1:0] calc_clr, output int lat);
    int  t0;
    bit  got;
    req_valid[k]      = 1'b1;
    mcand[k*N +: N]   = a;
    mplier[k*N +: N]  = b;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      got = acc_mask[k];
    end
    if (!got) cmp("accept_timeout", 0, 1);
    t0           = cyc - 1;
    req_valid[k] = 1'b0;
    ovr_clr      = calc_clr;
    cycle();
    ovr_clr      = '0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      got = s_valid;
    end
    if (!got) cmp("response_timeout", 0, 1);
    lat = (cyc - 1) - t0;
  endtask

  int lat;
  int order[$];
  int when[$];
  int exp_order[6] = '{0, 1, 2, 3, 0, 1};
  logic [N-1:0] held;

  initial begin
    rst = 1'b1; req_valid = '0; mcand = '0; mplier = '0; rsp_ready = 1'b1; ovr_clr = '0;
    @(negedge clk); @(negedge clk);
    ph_m = 0; ptr_m = 0; id_m = 0; res_m = '0; ovr_m = 1'b0; sticky_m = '0; zeros_m = 1'b1;
    acc_mask = '0;
    rst = 1'b0;

    // Hand-computed anchors for the reference multiplier.
    cmp("model_1x1", ref_mul(32'h0000_8000, 32'h0000_8000), 33'h0_0000_8000);
    cmp("model_neg", ref_mul(32'hFFFF_4000, 32'h0001_0000), 33'h0_FFFE_8000);
    cmp("model_ovr", ref_mul(32'h7FFF_0000, 32'h0001_0000), 33'h1_7FFE_0000);
    cmp("model_m1m1", ref_mul(32'hFFFF_8000, 32'hFFFF_8000), 33'h0_0000_8000);

    send(0, 32'h0000_8000, 32'h0000_8000, '0, lat);
    cmp("t1_latency", lat, 2);
    cmp("t1_result", s_result, 32'h0000_8000);
    cmp("t1_ovr", s_ovr, 0);
    cmp("t1_id", s_id, 0);

    send(2, 32'hFFFF_4000, 32'h0001_0000, '0, lat);
    cmp("t2_result", s_result, 32'hFFFE_8000);
    cmp("t2_ovr", s_ovr, 0);
    cmp("t2_id", s_id, 2);

    send(1, 32'h7FFF_0000, 32'h0001_0000, '0, lat);
    cmp("t3_result", s_result, 32'h7FFE_0000);
    cmp("t3_ovr", s_ovr, 1);
    cmp("t3_sticky_set", s_sticky, 4'b0010);
    ovr_clr = 4'b0010;
    cycle();
    ovr_clr = '0;
    cycle();
    cmp("t3_sticky_clr", s_sticky, 4'b0000);
    send(1, 32'h7FFF_0000, 32'h0001_0000, 4'b0010, lat);
    cmp("t3_set_wins", s_sticky, 4'b0010);
    cycle();

    // Four continuously-valid requesters from reset.
    do_reset();
    for (int k = 0; k < NREQ; k++) begin
      mcand[k*N +: N]  = rand_op();
      mplier[k*N +: N] = rand_op();
    end
    req_valid = 4'hF;
    for (int i = 0; i < 40 && order.size() < 6; i++) begin
      cycle();
      for (int k = 0; k < NREQ; k++) if (acc_mask[k]) begin
        order.push_back(k);
        when.push_back(cyc - 1);
      end
    end
    cmp("t4_count", order.size(), 6);
    for (int i = 0; i < 6 && i < order.size(); i++) cmp("t4_order", order[i], exp_order[i]);
    for (int i = 1; i < when.size(); i++) cmp("t4_spacing", when[i] - when[i-1], 3);
    req_valid = '0;
    repeat (4) cycle();

    // Response stalled for five cycles while another requester waits.
    rsp_ready = 1'b0;
    send(3, 32'h0002_8000, 32'hFFFF_0000, '0, lat);
    held = s_result;
    req_valid[0]   = 1'b1;
    mcand[0 +: N]  = 32'h0000_C000;
    mplier[0 +: N] = 32'h0000_C000;
    repeat (5) begin
      cycle();
      cmp("t5_hold_result", s_result, held);
      cmp("t5_hold_ready", s_ready, 4'b0000);
    end
    rsp_ready = 1'b1;
    cycle();
    cycle();
    cmp("t5_next_grant", s_ready, 4'b0001);
    req_valid = '0;
    repeat (4) cycle();

    // Reset while a transaction is in the multiply phase.
    req_valid = 4'hF;
    for (int i = 0; i < 10 && acc_mask == '0; i++) cycle();
    cmp("t6_accepted", acc_mask != '0, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    cmp("t6_ready_ptr0", s_ready, 4'b0001);
    cmp("t6_no_rsp", s_valid, 0);
    cmp("t6_sticky", s_sticky, 4'b0000);
    req_valid = '0;
    repeat (4) cycle();

    // Randomized traffic honouring the hold-until-ready protocol.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (req_valid[k] && acc_mask[k]) begin
          req_valid[k]     = $urandom_range(1, 0);
          mcand[k*N +: N]  = rand_op();
          mplier[k*N +: N] = rand_op();
        end else if (req_valid[k]) begin
          if ($urandom_range(9, 0) == 0) req_valid[k] = 1'b0;
        end else if ($urandom_range(2, 0) == 0) begin
          req_valid[k]     = 1'b1;
          mcand[k*N +: N]  = rand_op();
          mplier[k*N +: N] = rand_op();
        end
      end
      rsp_ready = ($urandom_range(9, 0) < 7);
      ovr_clr   = NREQ'($urandom) & NREQ'($urandom) & NREQ'($urandom);
      rst       = ($urandom_range(199, 0) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/qmult_sched.md
Name: qmult_sched

Overview:
Round-robin scheduler that shares a single combinational qmult fixed-point multiplier among NREQ requesters.
- Each requester has its own valid/ready handshake.
- The block registers the granted operands, drives them into one qmult instance, and captures the product and overflow flag into a response register with a valid/ready handshake.
- It sits between the fixed-point compute clients and the multiplier, so the arithmetic core is instantiated once rather than per client.

Parameters:
- Q, 15, fractional bits; passed to qmult.
- N, 32, total word width in bits, including sign; passed to qmult.
- NREQ, 4, number of requesters; legal range 2..16.
- IDW, clog2(NREQ), localparam; width of the requester ID.

Ports:
- i_clk  in  1  single clock; all state changes on its rising edge
- i_rst  in  1  synchronous, active-high reset
- i_req_valid  in  NREQ  per-requester operand-valid
- o_req_ready  out  NREQ  per-requester accept; one-hot or zero
- i_req_multiplicand  in  NREQ*N  flattened; requester k uses bits [k*N +: N]
- i_req_multiplier  in  NREQ*N  flattened; same layout
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response consumer ready
- o_rsp_id  out  IDW  index of the requester that owns the response
- o_rsp_result  out  N  Q-format product, as produced by qmult
- o_rsp_ovr  out  1  qmult overflow flag for this response
- o_ovr_sticky  out  NREQ  per-requester sticky overflow
- i_ovr_clr  in  NREQ  per-requester sticky clear
- o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous on i_rst): state=IDLE, RR pointer=0, o_rsp_valid=0, o_rsp_id=0, o_rsp_result=0, o_rsp_ovr=0, o_ovr_sticky=0, o_busy=0, operand registers=0. Reset overrides every other event, including mid-CALC and mid-DONE; an in-flight transaction is dropped silently.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - o_req_ready is the combinational round-robin grant over i_req_valid, searching from the pointer upward with wrap.
  - The grant is zero when no valid is asserted.
  - On accept (valid & ready for requester g): capture both operands and g, set pointer=(g+1) mod NREQ, go to CALC.
- CALC: o_req_ready=0. The operand registers feed qmult. At the end of the cycle, capture qmult o_result and ovr into o_rsp_result and o_rsp_ovr, set o_rsp_valid=1, go to DONE.
- DONE:
  - o_rsp_valid=1; o_rsp_id, o_rsp_result and o_rsp_ovr stay stable until the handshake.
  - When i_rsp_ready=1: clear o_rsp_valid and go to IDLE.
  - There is no bypass. The next grant is offered in the cycle after the handshake.
- Latency and throughput: accept at cycle T; o_rsp_valid rises at T+2; one transaction per 3 cycles minimum.
- Arithmetic: exactly qmult semantics.
  - Operands are converted to sign-magnitude.
  - Result = sign applied to product bits [N-2+Q:Q].
  - ovr = OR of product bits [2N-2:N-1+Q].
  - The scheduler does not saturate or alter the result.
  - The most-negative operand passes through unchanged.
- Sticky overflow:
  - o_ovr_sticky[id] is set on the CALC->DONE transition when ovr=1.
  - i_ovr_clr[k] clears bit k.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
  - Clears to other bits act independently.
- Requester protocol: a requester holds valid and operands stable until it sees ready. A valid with no grant has no side effect. Dropping valid before grant is permitted.
- Pointer fairness: every continuously-valid requester is granted within NREQ transactions.

Decomposition:
- Shared package/include qmult_sched_pkg:
  - state encodings: IDLE=2'd0, CALC=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE
  - a clog2 function used for IDW
- Sub-module rr_arbiter (parameter NREQ):
  - inputs: request vector, pointer
  - output: one-hot grant and encoded index
  - purely combinational
- qmult is instantiated once, unchanged, with Q and N passed through.

Test Plan:
1. Reset, then requester 0 sends 0x00008000 * 0x00008000 (1.0*1.0) -> o_req_ready[0] at T; o_rsp_valid at T+2 with result=0x00008000, ovr=0, id=0.
2. Requester 2 sends 0xFFFF4000 * 0x00010000 (-1.5*2.0) -> result=0xFFFE8000, ovr=0, id=2.
3. Requester 1 sends 0x7FFF0000 * 0x00010000 -> ovr=1, result=0x7FFE0000, o_ovr_sticky=4'b0010; then pulse i_ovr_clr[1] -> sticky=0. Repeat with the clear pulsed in the CALC->DONE cycle -> sticky remains 1.
4. All four valid continuously from reset, i_rsp_ready=1 -> grant order 0,1,2,3,0,1; one response every 3 cycles; ids match grant order.
5. i_rsp_ready=0 for 5 cycles in DONE -> o_rsp_valid and data held stable, o_req_ready=0; the cycle after ready rises, IDLE is reached and the next grant appears.
6. i_rst asserted during CALC -> next cycle IDLE, o_rsp_valid=0, pointer=0, sticky=0; no response emitted for the dropped transaction.
